// File: rtl/operand_entry_fsm.sv
// Keypad-to-adder operand entry: assembles two hex operands from key events
// and hands them to the arithmetic FSM via new_input / finish_input pulses.
module operand_entry_fsm #(
  parameter int MAX_DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                key_code,
  input  logic                      key_valid,
  output logic [4*MAX_DIGITS-1:0]   num1_hex,
  output logic [4*MAX_DIGITS-1:0]   num2_hex,
  output logic                      new_input,
  output logic                      finish_input,
  output logic [4*MAX_DIGITS-1:0]   display_hex,
  output logic [1:0]                state_out,
  output logic [1:0]                digit_cnt
);

  localparam int W = 4 * MAX_DIGITS;
  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {
    OP1  = 2'd0,
    OP2  = 2'd1,
    DONE = 2'd2,
    BAD  = 2'd3
  } state_t;

  state_t       state, state_next;
  logic         kv_d;
  logic         key_event, is_enter, is_clear;
  logic [W-1:0] num1_next, num2_next;
  logic [1:0]   cnt_next;
  logic         new_next, fin_next;

  // One event per press: rising edge of the held key level.
  assign key_event = key_valid & ~kv_d;
  assign is_enter  = (key_code == 4'hE);
  assign is_clear  = (key_code == 4'hF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= OP1;
      kv_d         <= 1'b0;
      num1_hex     <= '0;
      num2_hex     <= '0;
      digit_cnt    <= '0;
      new_input    <= 1'b0;
      finish_input <= 1'b0;
    end else begin
      state        <= state_next;
      kv_d         <= key_valid;
      num1_hex     <= num1_next;
      num2_hex     <= num2_next;
      digit_cnt    <= cnt_next;
      new_input    <= new_next;
      finish_input <= fin_next;
    end
  end

  always_comb begin
    state_next = state;
    num1_next  = num1_hex;
    num2_next  = num2_hex;
    cnt_next   = digit_cnt;
    new_next   = 1'b0;
    fin_next   = 1'b0;
    if (key_event && is_clear) begin
      state_next = OP1;
      num1_next  = '0;
      num2_next  = '0;
      cnt_next   = '0;
    end else begin
      case (state)
        OP1, OP2: begin
          if (key_event) begin
            if (is_enter) begin
              if (state == OP1) begin
                state_next = OP2;
                cnt_next   = '0;
                num2_next  = '0;
              end else begin
                state_next = DONE;
                new_next   = 1'b1;
              end
            end else if (digit_cnt < MAX_CNT) begin
              if (state == OP1) num1_next = (num1_hex << 4) | W'(key_code);
              else              num2_next = (num2_hex << 4) | W'(key_code);
              cnt_next = digit_cnt + 2'd1;
            end
          end
        end
        DONE: begin
          if (key_event && is_enter) begin
            state_next = OP1;
            fin_next   = 1'b1;
            num1_next  = '0;
            num2_next  = '0;
            cnt_next   = '0;
          end
        end
        default: state_next = OP1;
      endcase
    end
  end

  always_comb begin
    state_out   = state;
    display_hex = (state == OP1) ? num1_hex : num2_hex;
  end

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed table-driven bench for operand_entry_fsm plus hand-written
// sequences for held keys and asynchronous reset.
module tb_operand_entry_fsm;

  logic        clk, rst, key_valid;
  logic [3:0]  key_code;
  logic [11:0] num1_hex, num2_hex, display_hex;
  logic        new_input, finish_input;
  logic [1:0]  state_out, digit_cnt;

  int total = 0;
  int bad   = 0;
  int n_new = 0;
  int n_fin = 0;
  logic [11:0] cap1, cap2;

  operand_entry_fsm #(.MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .num1_hex(num1_hex), .num2_hex(num2_hex), .new_input(new_input),
    .finish_input(finish_input), .display_hex(display_hex),
    .state_out(state_out), .digit_cnt(digit_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Each high cycle of a pulse is counted once; operands captured at new_input.
  always @(negedge clk) begin
    if (new_input) begin
      n_new = n_new + 1;
      cap1  = num1_hex;
      cap2  = num2_hex;
    end
    if (finish_input) n_fin = n_fin + 1;
  end

  typedef struct {
    logic [3:0]  code;
    logic [11:0] n1;
    logic [11:0] n2;
    logic [1:0]  st;
    logic [1:0]  cnt;
    int          nnew;
    int          nfin;
  } vec_t;

  vec_t rows[20];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    @(negedge clk);
    key_code  = code;
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [11:0] e1,
                         input logic [11:0] e2, input logic [1:0] es, input logic [1:0] ec);
    chk({tag, "_num1"}, idx, 32'(num1_hex), 32'(e1));
    chk({tag, "_num2"}, idx, 32'(num2_hex), 32'(e2));
    chk({tag, "_state"}, idx, 32'(state_out), 32'(es));
    chk({tag, "_cnt"}, idx, 32'(digit_cnt), 32'(ec));
    chk({tag, "_disp"}, idx, 32'(display_hex), 32'((es == 2'd0) ? e1 : e2));
  endtask

  initial begin
    rows[0]  = '{4'h5, 12'h005, 12'h000, 2'd0, 2'd1, 0, 0};
    rows[1]  = '{4'hE, 12'h005, 12'h000, 2'd1, 2'd0, 0, 0};
    rows[2]  = '{4'h3, 12'h005, 12'h003, 2'd1, 2'd1, 0, 0};
    rows[3]  = '{4'hE, 12'h005, 12'h003, 2'd2, 2'd1, 1, 0};
    rows[4]  = '{4'h7, 12'h005, 12'h003, 2'd2, 2'd1, 0, 0};
    rows[5]  = '{4'hE, 12'h000, 12'h000, 2'd0, 2'd0, 0, 1};
    rows[6]  = '{4'h1, 12'h001, 12'h000, 2'd0, 2'd1, 0, 0};
    rows[7]  = '{4'h2, 12'h012, 12'h000, 2'd0, 2'd2, 0, 0};
    rows[8]  = '{4'h3, 12'h123, 12'h000, 2'd0, 2'd3, 0, 0};
    rows[9]  = '{4'h4, 12'h123, 12'h000, 2'd0, 2'd3, 0, 0};
    rows[10] = '{4'hF, 12'h000, 12'h000, 2'd0, 2'd0, 0, 0};
    rows[11] = '{4'hE, 12'h000, 12'h000, 2'd1, 2'd0, 0, 0};
    rows[12] = '{4'hE, 12'h000, 12'h000, 2'd2, 2'd0, 1, 0};
    rows[13] = '{4'hF, 12'h000, 12'h000, 2'd0, 2'd0, 0, 0};
    rows[14] = '{4'h7, 12'h007, 12'h000, 2'd0, 2'd1, 0, 0};
    rows[15] = '{4'hE, 12'h007, 12'h000, 2'd1, 2'd0, 0, 0};
    rows[16] = '{4'h9, 12'h007, 12'h009, 2'd1, 2'd1, 0, 0};
    rows[17] = '{4'hF, 12'h000, 12'h000, 2'd0, 2'd0, 0, 0};
    rows[18] = '{4'hD, 12'h00D, 12'h000, 2'd0, 2'd1, 0, 0};
    rows[19] = '{4'hF, 12'h000, 12'h000, 2'd0, 2'd0, 0, 0};

    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    cap1      = '1;
    cap2      = '1;
    #1;
    chk_all("reset", 0, 12'h000, 12'h000, 2'd0, 2'd0);
    chk("reset_new", 0, 32'(new_input), 32'd0);
    chk("reset_fin", 0, 32'(finish_input), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      n_new = 0;
      n_fin = 0;
      press(rows[i].code, 4);
      chk_all("row", i, rows[i].n1, rows[i].n2, rows[i].st, rows[i].cnt);
      chk("row_new", i, 32'(n_new), 32'(rows[i].nnew));
      chk("row_fin", i, 32'(n_fin), 32'(rows[i].nfin));
      if (rows[i].nnew == 1) begin
        chk("cap_num1", i, 32'(cap1), 32'(rows[i].n1));
        chk("cap_num2", i, 32'(cap2), 32'(rows[i].n2));
      end
    end

    // Held key: one event across 50 cycles.
    n_new = 0;
    press(4'hA, 50);
    chk_all("held", 0, 12'h00A, 12'h000, 2'd0, 2'd1);
    press(4'hF, 2);

    // Reset asserted while new_input is high truncates the pulse at once.
    press(4'h1, 2);
    press(4'hE, 2);
    chk_all("pre_rst", 0, 12'h001, 12'h000, 2'd1, 2'd0);
    @(negedge clk);
    key_code  = 4'hE;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("trunc_pulse_seen", 0, 32'(new_input), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("trunc_new", 0, 32'(new_input), 32'd0);
    chk_all("async_rst", 0, 12'h000, 12'h000, 2'd0, 2'd0);
    key_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_new = 0;
    press(4'h6, 3);
    chk_all("post_rst", 0, 12'h006, 12'h000, 2'd0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
